// File: rtl/lc3_inst_mem_responder_pkg.sv
// Shared types and constants for the LC3 instruction-memory responder slice.
package inst_mem_pkg_hdl;

  localparam int unsigned INST_ADDR_W = 16;
  localparam int unsigned INST_DATA_W = 16;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_DATA_W-1:0] inst_data_t;

  localparam inst_data_t LC3_NOP           = 16'h0000;
  localparam inst_addr_t DEFAULT_BASE_ADDR = 16'h3000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == '1) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/lc3_inst_mem_responder_if.sv
// Fetch and program-load bus between the LC3 fetch side (master) and the responder (slave).
interface lc3_inst_mem_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] PC;
  logic              instrmem_rd;
  logic [DATA_W-1:0] Instr_dout;
  logic              rd_valid;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [15:0]       rd_count;
  logic [15:0]       oor_count;

  modport master (
    output PC, instrmem_rd, ld_en, ld_addr, ld_data,
    input  Instr_dout, rd_valid, rd_count, oor_count
  );

  modport slave (
    input  PC, instrmem_rd, ld_en, ld_addr, ld_data,
    output Instr_dout, rd_valid, rd_count, oor_count
  );
endinterface

// File: rtl/lc3_inst_mem_responder_delay_pipe.sv
// Valid+data delay line; each data stage loads only when a valid word enters it,
// so the last stage always holds the most recent response.
module lc3_inst_mem_delay_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic [STAGES-1:0] valid;
  logic [WIDTH-1:0]  data [STAGES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int unsigned i = 0; i < STAGES; i++) data[i] <= '0;
    end else begin
      valid[0] <= in_valid;
      if (in_valid) data[0] <= in_data;
      for (int unsigned i = 1; i < STAGES; i++) begin
        valid[i] <= valid[i-1];
        if (valid[i-1]) data[i] <= data[i-1];
      end
    end
  end

  assign out_valid = valid[STAGES-1];
  assign out_data  = data[STAGES-1];
endmodule

// File: rtl/lc3_inst_mem_responder.sv
// Instruction-memory responder: synchronous RAM answering LC3 fetches after
// READ_LATENCY cycles, with a side load port and saturating read statistics.
module lc3_inst_mem_responder
  import inst_mem_pkg_hdl::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       DEPTH_LOG2   = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int unsigned       READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] OOR_DATA     = LC3_NOP
) (
  input  logic                     clock,
  input  logic                     reset,
  lc3_inst_mem_responder_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0]     rd_off;
  logic [ADDR_W-1:0]     ld_off;
  logic                  rd_mapped;
  logic                  ld_mapped;
  logic                  head_valid;
  logic [DATA_W-1:0]     head_data;
  logic [15:0]           rd_count;
  logic [15:0]           oor_count;

  // Offsets use ADDR_W wrap arithmetic, so addresses below BASE_ADDR land far out of range.
  assign rd_off    = bus.PC - BASE_ADDR;
  assign ld_off    = bus.ld_addr - BASE_ADDR;
  assign rd_mapped = 32'(rd_off) < DEPTH;
  assign ld_mapped = 32'(ld_off) < DEPTH;

  always_ff @(posedge clock) begin
    if (bus.ld_en && ld_mapped) mem[ld_off[DEPTH_LOG2-1:0]] <= bus.ld_data;
  end

  // First latency stage is the RAM read register; non-blocking write gives read-before-write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      head_valid <= bus.instrmem_rd;
      if (bus.instrmem_rd) head_data <= rd_mapped ? mem[rd_off[DEPTH_LOG2-1:0]] : OOR_DATA;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count  <= '0;
      oor_count <= '0;
    end else if (bus.instrmem_rd) begin
      rd_count <= sat_inc16(rd_count);
      if (!rd_mapped) oor_count <= sat_inc16(oor_count);
    end
  end

  generate
    if (READ_LATENCY > 1) begin : g_delay
      lc3_inst_mem_delay_pipe #(
        .WIDTH  (DATA_W),
        .STAGES (READ_LATENCY - 1)
      ) u_delay (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (head_valid),
        .in_data   (head_data),
        .out_valid (bus.rd_valid),
        .out_data  (bus.Instr_dout)
      );
    end else begin : g_direct
      assign bus.rd_valid   = head_valid;
      assign bus.Instr_dout = head_data;
    end
  endgenerate

  assign bus.rd_count  = rd_count;
  assign bus.oor_count = oor_count;
endmodule
